// File: rtl/hazard_pkg.sv
// Shared types and latency defaults for the register hazard scoreboard.
// lat_of maps an instruction latency class to the cycles until its result can be forwarded.
package hazard_pkg;

    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_LOAD = 2'd1,
        LAT_MUL  = 2'd2,
        LAT_RSVD = 2'd3
    } lat_class_e;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_REG_W    = 5;
    localparam int DEF_LOAD_LAT = 2;
    localparam int DEF_MUL_LAT  = 5;
    localparam int DEF_CNT_W    = 3;
    localparam int DEF_FWD_EN   = 1;

    // The reserved class is treated as the slowest (MUL) class.
    // The caller truncates the result to its own countdown width.
    function automatic int unsigned lat_of(input lat_class_e  cls,
                                           input int unsigned load_lat,
                                           input int unsigned mul_lat);
        int unsigned lat;
        case (cls)
            LAT_ALU:  lat = 1;
            LAT_LOAD: lat = load_lat;
            default:  lat = mul_lat;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// Scoreboard entry for one architectural register: pending flag plus remaining-latency countdown.
// Entries update one cycle after set/clear; i_hold freezes the countdown while memory is stalled.
module sb_entry #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_set,
    input  logic [CNT_W-1:0] i_set_cnt,
    input  logic             i_clear,
    input  logic             i_dec,
    input  logic             i_hold,
    output logic             o_pend,
    output logic             o_ready
);

    logic             r_pend;
    logic [CNT_W-1:0] r_cnt;

    // The issue cycle already counts as one elapsed cycle of latency unless memory is frozen,
    // so a 1-cycle ALU result is ready for the very next decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 1'b0;
            r_cnt  <= '0;
        end else if (i_set) begin
            r_pend <= 1'b1;
            if (i_hold || (i_set_cnt == '0)) begin
                r_cnt <= i_set_cnt;
            end else begin
                r_cnt <= i_set_cnt - CNT_W'(1);
            end
        end else if (i_clear) begin
            r_pend <= 1'b0;
            r_cnt  <= '0;
        end else if (i_dec && !i_hold && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_pend  = r_pend;
    assign o_ready = (r_cnt == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: combinational stall and bypass requests from in-flight write state.
// Stall releases in the same cycle the producer becomes forwardable or writes back.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_W    = DEF_REG_W,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int MUL_LAT  = DEF_MUL_LAT,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int FWD_EN   = DEF_FWD_EN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [REG_W-1:0] d_src_reg_1,
    input  logic [REG_W-1:0] d_src_reg_2,
    input  logic             d_src_used_1,
    input  logic             d_src_used_2,
    input  logic [REG_W-1:0] d_dst_reg,
    input  logic             d_reg_write,
    input  logic [1:0]       d_lat_class,
    input  logic             m_stall,
    input  logic [REG_W-1:0] w_dst_reg,
    input  logic             w_reg_write,
    output logic             f_stall,
    output logic             d_stall,
    output logic             fwd_1,
    output logic             fwd_2,
    output logic [31:0]      stall_cycles
);

    logic [NUM_REGS-1:0] w_pend;
    logic [NUM_REGS-1:0] w_ready;
    logic [CNT_W-1:0]    w_lat;
    logic                w_issue_wr;
    logic                w_haz_1;
    logic                w_haz_2;
    logic                w_notready_1;
    logic                w_notready_2;
    logic                w_waw;
    logic                w_stall;
    logic [31:0]         r_stall_cycles;

    assign w_lat = CNT_W'(lat_of(lat_class_e'(d_lat_class), LOAD_LAT, MUL_LAT));

    // Register 0 is hardwired zero: never pending, always ready.
    assign w_pend[0]  = 1'b0;
    assign w_ready[0] = 1'b1;

    assign w_issue_wr = d_valid && !w_stall && d_reg_write && (d_dst_reg != '0);

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
        sb_entry #(
            .CNT_W (CNT_W)
        ) u_entry (
            .clk       (clk),
            .reset     (reset),
            .i_set     (w_issue_wr && (d_dst_reg == REG_W'(g))),
            .i_set_cnt (w_lat),
            .i_clear   (w_reg_write && (w_dst_reg == REG_W'(g))),
            .i_dec     (w_pend[g]),
            .i_hold    (m_stall),
            .o_pend    (w_pend[g]),
            .o_ready   (w_ready[g])
        );
    end

    // A source being written back this cycle reads the fresh value from the register file.
    always_comb begin
        w_haz_1 = d_src_used_1 && (d_src_reg_1 != '0) && w_pend[d_src_reg_1]
                  && !(w_reg_write && (w_dst_reg == d_src_reg_1));
        w_haz_2 = d_src_used_2 && (d_src_reg_2 != '0) && w_pend[d_src_reg_2]
                  && !(w_reg_write && (w_dst_reg == d_src_reg_2));
        w_notready_1 = w_haz_1 && (!w_ready[d_src_reg_1] || (FWD_EN == 0));
        w_notready_2 = w_haz_2 && (!w_ready[d_src_reg_2] || (FWD_EN == 0));
        w_waw = d_reg_write && (d_dst_reg != '0) && w_pend[d_dst_reg]
                && !(w_reg_write && (w_dst_reg == d_dst_reg));
        w_stall = !reset && d_valid && (w_notready_1 || w_notready_2 || w_waw);
    end

    assign d_stall = w_stall;
    assign f_stall = w_stall;
    assign fwd_1   = !reset && d_valid && w_haz_1 && !w_notready_1;
    assign fwd_2   = !reset && d_valid && w_haz_2 && !w_notready_2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule
